h75_rx_capture: RTL and testbench

//  HUB75 receive-side capture: samples a HUB75 bus (as a panel sees it) and rebuilds framebuffer writes.

---
 rtl/h75_pkg.sv | 24 ++
 rtl/h75_rx_line_buffer.sv | 28 ++
 rtl/h75_rx_capture.sv | 212 +++++++++++++++++++++
 tb/tb_h75_rx_capture.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h75_pkg.sv
// rtl/h75_pkg.sv - shared widths, status bit positions and address packing for the HUB75 capture block
package h75_pkg;
  localparam int ROW_W   = 5;
  localparam int PLANE_W = 3;
  localparam int COL_W   = 7;
  localparam int RGB_W   = 6;
  localparam int ADDR_W  = PLANE_W + ROW_W + COL_W;

  localparam int ST_LEN_ERR   = 0;
  localparam int ST_COL_OVF   = 1;
  localparam int ST_PLANE_ERR = 2;
  localparam int ST_OVERRUN   = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } drain_state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [PLANE_W-1:0] plane,
                                                  input logic [ROW_W-1:0]   row,
                                                  input logic [COL_W-1:0]   col);
    return {plane, row, col};
  endfunction
endpackage

// File: rtl/h75_rx_line_buffer.sv
// rtl/h75_rx_line_buffer.sv - ping-pong line store: one bank fills from the bus while the other drains
module h75_rx_line_buffer #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 6,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [2*DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Fill and drain always target opposite banks, so no read/write collision handling is needed.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
    r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/h75_rx_capture.sv
// rtl/h75_rx_capture.sv - HUB75 bus sniffer: oversamples the panel bus and replays each latched line as framebuffer writes
module h75_rx_capture
  import h75_pkg::*;
#(
  parameter int MAX_COLS      = 128,
  parameter int NUM_PLANES    = 6,
  parameter int OE_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              led_clk_in,
  input  logic              latch_in,
  input  logic              oe_in,
  input  logic [ROW_W-1:0]  abcde_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [9:0]        pixels_per_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [RGB_W-1:0]  out_data,
  output logic              frame_start,
  output logic [15:0]       oe_cycles,
  output logic [3:0]        status
);
  localparam int IDX_W = $clog2(MAX_COLS);
  localparam int CNT_W = $clog2(MAX_COLS + 1);
  localparam int BUS_W = 3 + ROW_W + RGB_W;

  logic [BUS_W-1:0]   r_sync1, r_sync2;
  logic               r_led_prev, r_latch_prev;
  logic [CNT_W-1:0]   r_col;
  logic               r_bank;
  logic               r_have_last;
  logic [ROW_W-1:0]   r_last_row;
  logic [3:0]         r_last_plane;
  logic [3:0]         r_status;
  logic               r_frame_start;
  logic [15:0]        r_oe_cnt, r_oe_cycles;
  logic [CNT_W-1:0]   r_drain_len;
  logic [ROW_W-1:0]   r_drain_row;
  logic [PLANE_W-1:0] r_drain_plane;
  logic [IDX_W-1:0]   r_idx;
  logic               r_primed;
  drain_state_t       r_state, w_next_state;

  logic               w_led, w_latch, w_oe_act;
  logic [ROW_W-1:0]   w_row;
  logic [RGB_W-1:0]   w_rgb;
  logic               w_led_rise, w_latch_rise;
  logic               w_col_full, w_wr_en;
  logic [CNT_W-1:0]   w_len;
  logic [3:0]         w_plane_calc;
  logic               w_busy, w_accept, w_plane_ok, w_start_drain;
  logic               w_valid, w_take, w_last;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [RGB_W-1:0]   w_rd_data;

  // All bus bits share one synchroniser so data, address and strobes stay cycle-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_led_prev   <= 1'b0;
      r_latch_prev <= 1'b0;
    end else begin
      r_sync1      <= {led_clk_in, latch_in, oe_in, abcde_in, rgb_in};
      r_sync2      <= r_sync1;
      r_led_prev   <= w_led;
      r_latch_prev <= w_latch;
    end
  end

  assign w_led        = r_sync2[BUS_W-1];
  assign w_latch      = r_sync2[BUS_W-2];
  assign w_oe_act     = (OE_ACTIVE_LOW != 0) ? ~r_sync2[BUS_W-3] : r_sync2[BUS_W-3];
  assign w_row        = r_sync2[RGB_W +: ROW_W];
  assign w_rgb        = r_sync2[RGB_W-1:0];
  assign w_led_rise   = w_led & ~r_led_prev;
  assign w_latch_rise = w_latch & ~r_latch_prev;

  // A pixel arriving with the latch is counted into the line being committed.
  assign w_col_full    = (r_col == CNT_W'(MAX_COLS));
  assign w_wr_en       = w_led_rise && !w_col_full;
  assign w_len         = r_col + CNT_W'(w_wr_en);
  assign w_plane_calc  = (r_have_last && (w_row == r_last_row)) ?
                         ((r_last_plane == 4'hF) ? 4'hF : r_last_plane + 4'd1) : 4'd0;
  assign w_busy        = (r_state == S_DRAIN);
  assign w_accept      = w_latch_rise && !w_busy;
  assign w_plane_ok    = (w_plane_calc < 4'(NUM_PLANES));
  assign w_start_drain = w_accept && w_plane_ok && (w_len != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col         <= '0;
      r_bank        <= 1'b0;
      r_have_last   <= 1'b0;
      r_last_row    <= '0;
      r_last_plane  <= '0;
      r_status      <= '0;
      r_frame_start <= 1'b0;
      r_oe_cnt      <= '0;
      r_oe_cycles   <= '0;
      r_drain_len   <= '0;
      r_drain_row   <= '0;
      r_drain_plane <= '0;
    end else begin
      r_frame_start <= w_accept && w_plane_ok && (w_row == '0) && (w_plane_calc == 4'd0);
      if (w_led_rise && w_col_full) begin
        r_status[ST_COL_OVF] <= 1'b1;
      end
      if (w_latch_rise) begin
        r_col       <= '0;
        r_oe_cycles <= r_oe_cnt;
        r_oe_cnt    <= '0;
        if (w_busy) begin
          r_status[ST_OVERRUN] <= 1'b1;
        end else begin
          r_bank       <= ~r_bank;
          r_have_last  <= 1'b1;
          r_last_row   <= w_row;
          r_last_plane <= w_plane_calc;
          if (10'(w_len) != pixels_per_row) begin
            r_status[ST_LEN_ERR] <= 1'b1;
          end
          if (!w_plane_ok) begin
            r_status[ST_PLANE_ERR] <= 1'b1;
          end
          if (w_start_drain) begin
            r_drain_len   <= w_len;
            r_drain_row   <= w_row;
            r_drain_plane <= w_plane_calc[PLANE_W-1:0];
          end
        end
      end else begin
        if (w_wr_en) begin
          r_col <= r_col + 1'b1;
        end
        if (w_oe_act && (r_oe_cnt != 16'hFFFF)) begin
          r_oe_cnt <= r_oe_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_drain) w_next_state = S_DRAIN;
      S_DRAIN: if (w_take && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // r_primed covers the one-cycle RAM read before the first word is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx    <= '0;
      r_primed <= 1'b0;
    end else if (w_start_drain) begin
      r_idx    <= '0;
      r_primed <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      if (!r_primed) begin
        r_primed <= 1'b1;
      end else if (w_take) begin
        if (w_last) begin
          r_idx    <= '0;
          r_primed <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign w_take   = w_valid && out_ready;
  assign w_last   = ((CNT_W'(r_idx) + 1'b1) == r_drain_len);
  assign w_rd_idx = (w_take && !w_last) ? r_idx + 1'b1 : r_idx;

  always_comb begin
    w_valid   = (r_state == S_DRAIN) && r_primed;
    out_valid = w_valid;
    out_addr  = w_valid ? pack_addr(r_drain_plane, r_drain_row, COL_W'(r_idx)) : '0;
    out_data  = w_valid ? w_rd_data : '0;
  end

  h75_rx_line_buffer #(
    .DEPTH  (MAX_COLS),
    .DATA_W (RGB_W)
  ) u_line_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_bank (r_bank),
    .i_wr_addr (r_col[IDX_W-1:0]),
    .i_wr_data (w_rgb),
    .i_rd_bank (~r_bank),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_rd_data)
  );

  assign frame_start = r_frame_start;
  assign oe_cycles   = r_oe_cycles;
  assign status      = r_status;
endmodule

// File: tb/tb_h75_rx_capture.sv
// tb/tb_h75_rx_capture.sv - randomized bench for h75_rx_capture with a line-level reference model
module tb_h75_rx_capture;
  localparam int MAXC = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        led_clk_in, latch_in, oe_in;
  logic [4:0]  abcde_in;
  logic [5:0]  rgb_in;
  logic [9:0]  ppr;
  logic        out_valid, out_ready;
  logic [14:0] out_addr;
  logic [5:0]  out_data;
  logic        frame_start;
  logic [15:0] oe_cycles;
  logic [3:0]  status;

  always #5 clk = ~clk;

  h75_rx_capture dut (
    .clk            (clk),
    .reset          (reset),
    .led_clk_in     (led_clk_in),
    .latch_in       (latch_in),
    .oe_in          (oe_in),
    .abcde_in       (abcde_in),
    .rgb_in         (rgb_in),
    .pixels_per_row (ppr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .frame_start    (frame_start),
    .oe_cycles      (oe_cycles),
    .status         (status)
  );

  int checks = 0, errors = 0;
  logic [20:0] exp_q[$];
  logic [20:0] log_q[$];
  logic [5:0]  line_px[$];
  bit          m_has_last;
  int          m_last_row, m_last_plane, m_frames, seen_frames;
  logic [3:0]  m_status;
  bit          rand_ready;
  int          ready_pct;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    line_px.delete();
    m_has_last = 0;
    m_last_row = 0;
    m_last_plane = 0;
    m_status = 4'h0;
  endtask

  // Line-level model: one commit turns the queued pixels into the words the framebuffer must see.
  task automatic model_commit(input int row, input bit busy);
    int n, len, plane;
    n = line_px.size();
    len = (n > MAXC) ? MAXC : n;
    if (busy) begin
      m_status[3] = 1'b1;
    end else begin
      if (len != int'(ppr)) m_status[0] = 1'b1;
      plane = (m_has_last && row == m_last_row) ? ((m_last_plane + 1 > 15) ? 15 : m_last_plane + 1) : 0;
      m_has_last = 1;
      m_last_row = row;
      m_last_plane = plane;
      if (plane >= 6) begin
        m_status[2] = 1'b1;
      end else begin
        for (int i = 0; i < len; i++)
          exp_q.push_back({plane[2:0], row[4:0], i[6:0], line_px[i]});
        if (row == 0 && plane == 0) m_frames++;
      end
    end
    line_px.delete();
  endtask

  task automatic shift_px(input logic [5:0] d);
    @(negedge clk);
    rgb_in = d;
    led_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    led_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    led_clk_in = 1'b0;
    if (line_px.size() >= MAXC) m_status[1] = 1'b1;
    line_px.push_back(d);
  endtask

  task automatic shift_rand(input int n);
    for (int i = 0; i < n; i++) shift_px(6'($urandom));
  endtask

  task automatic latch_line(input int row, input bit busy, input bit measure);
    @(negedge clk);
    abcde_in = row[4:0];
    repeat (2) @(negedge clk);
    model_commit(row, busy);
    latch_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (measure) check($sformatf("latency_valid_at_%0d", k), out_valid, (k == 4));
    end
    latch_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic oe_pulse(input int k);
    @(negedge clk);
    oe_in = 1'b0;
    repeat (k) @(negedge clk);
    oe_in = 1'b1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d words_left expected=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Compare process: every accepted word against the model queue, plus AXI hold and frame_start width.
  bit          pv, pr, pfs;
  logic [20:0] pword;
  logic [20:0] e;
  always @(negedge clk) begin
    if (reset) begin
      pv = 0;
      pr = 0;
      pfs = 0;
    end else begin
      if (frame_start) begin
        seen_frames++;
        check("frame_start_one_cycle", pfs, 1'b0);
      end
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_word", {out_addr, out_data}, pword);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h expected=none", {out_addr, out_data});
        end else begin
          e = exp_q.pop_front();
          check("word", {out_addr, out_data}, e);
        end
        log_q.push_back({out_addr, out_data});
      end
      pv = out_valid;
      pr = out_ready;
      pfs = frame_start;
      pword = {out_addr, out_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  int base, k;
  initial begin
    reset = 1'b1;
    led_clk_in = 1'b0;
    latch_in = 1'b0;
    oe_in = 1'b1;
    abcde_in = '0;
    rgb_in = '0;
    ppr = 10'd64;
    out_ready = 1'b1;
    rand_ready = 0;
    ready_pct = 100;
    m_frames = 0;
    seen_frames = 0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_status", status, 4'h0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_oe_cycles", oe_cycles, 16'h0);
    check("rst_addr", out_addr, 15'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Four pixels on row 3 with a 64-pixel length expectation.
    shift_px(6'h3F); shift_px(6'h01); shift_px(6'h2A); shift_px(6'h15);
    latch_line(3, 0, 1);
    wait_drain();
    check("t1_count", log_q.size(), 4);
    check("t1_w0", log_q[0], {15'h0180, 6'h3F});
    check("t1_w1", log_q[1], {15'h0181, 6'h01});
    check("t1_w2", log_q[2], {15'h0182, 6'h2A});
    check("t1_w3", log_q[3], {15'h0183, 6'h15});
    check("t1_status", status, 4'b0001);

    // Seven latches on row 5: planes 0..5 then a plane error.
    ppr = 10'd2;
    for (int i = 0; i < 7; i++) begin
      shift_rand(2);
      latch_line(5, 0, 0);
      wait_drain();
    end
    check("t2_count", log_q.size(), 16);
    check("t2_last_plane", log_q[15][20:18], 3'd5);
    check("t2_status", status, 4'b0101);

    // Row 31 plane 0, then row 0 starts a frame.
    ppr = 10'd4;
    shift_rand(4); latch_line(31, 0, 0); wait_drain();
    shift_rand(4); latch_line(0, 0, 0); wait_drain();
    check("t3_frames", seen_frames, 1);
    check("t3_addr_hi", log_q[log_q.size()-1][20:13], 8'h00);

    // 130 pixels into a 128-column line.
    ppr = 10'd128;
    base = log_q.size();
    shift_rand(130);
    latch_line(7, 0, 0);
    wait_drain();
    check("t4_count", log_q.size() - base, 128);
    check("t4_last_col", log_q[log_q.size()-1][12:6], 7'd127);
    check("t4_status", status, 4'b0111);

    // Overrun: B lands while A is stalled, A still drains intact.
    ppr = 10'd3;
    out_ready = 1'b0;
    shift_rand(3); latch_line(9, 0, 0);
    shift_rand(2); latch_line(9, 1, 0);
    check("t5_overrun", status[3], 1'b1);
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    shift_rand(3); latch_line(9, 0, 0); wait_drain();
    check("t5_plane_after", log_q[log_q.size()-1][20:18], 3'd1);
    check("t5_status", status, m_status);

    // Reset while a line is being drained.
    out_ready = 1'b0;
    shift_rand(3); latch_line(2, 0, 0);
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    check("t6_valid_before_reset", out_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("t6_valid_after_reset", out_valid, 1'b0);
    check("t6_status_after_reset", status, 4'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    ppr = 10'd2;
    shift_rand(2); latch_line(2, 0, 0); wait_drain();
    check("t6_clean_plane", log_q[log_q.size()-1][20:18], 3'd0);
    check("t6_clean_status", status, 4'h0);

    // Randomized lines with random backpressure and oe pulses.
    rand_ready = 1;
    ready_pct = 60;
    for (int it = 0; it < 25; it++) begin
      ppr = 10'($urandom_range(1, 6));
      shift_rand($urandom_range(0, 7));
      k = ($urandom_range(1) == 1) ? $urandom_range(1, 30) : 0;
      if (k > 0) oe_pulse(k);
      latch_line($urandom_range(0, 2), 0, 0);
      check("rnd_oe_cycles", oe_cycles, k);
      wait_drain();
      check("rnd_status", status, m_status);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("end_queue_empty", exp_q.size(), 0);
    check("end_frames", seen_frames, m_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
